data_ram_be: RTL and testbench
==============================

Name: data_ram_be

Overview:
- Parametrised successor to the single-port synchronous data memory.
- Adds per-byte write enables, a request/valid read handshake and an optional output pipeline register.
- Adds an automatic zero-fill sweep after reset or on command, with a ready flag.
- Sits between the core's load/store unit and the data address space. Serves word reads and byte/halfword/word stores.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8; lanes = DATA_WIDTH/8.
- ADDR_WIDTH, 12, word address width; depth = 2**ADDR_WIDTH words.
- OUT_REG, 0, 0 = read latency 1 cycle; 1 = extra output register, read latency 2 cycles.
- CLEAR_ON_RESET, 1, 1 = zero-fill sweep starts on reset release; 0 = ready immediately after reset, contents undefined.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  access request, sampled on rising clk.
- we  input  1  1 = write, 0 = read; qualified by req.
- be  input  DATA_WIDTH/8  byte-lane write enables; bit i covers data[8i+7:8i].
- data  input  DATA_WIDTH  write data.
- address  input  ADDR_WIDTH  word address.
- clear  input  1  single-cycle pulse starts a zero-fill sweep.
- q  output  DATA_WIDTH  read data.
- q_valid  output  1  one-cycle pulse, q holds data of a completed read.
- ready  output  1  1 = memory accepts requests.

Behaviour:

Reset (asynchronous, active-high), while asserted:
- q = 0, q_valid = 0, sweep counter = 0, read pipeline flags = 0.
- FSM = SWEEP and ready = 0 if CLEAR_ON_RESET = 1.
- FSM = READY and ready = 1 if CLEAR_ON_RESET = 0.
- Memory array is not reset asynchronously.

FSM states and transitions:
- SWEEP:
  - Each cycle writes all-zero to word[cnt], then cnt increments.
  - After the cycle writing word 2**ADDR_WIDTH-1, go to READY; ready = 1 from the next cycle.
  - Sweep takes exactly 2**ADDR_WIDTH cycles.
  - req is ignored entirely: no write, no q_valid.
  - clear is ignored; the sweep is not restarted.
- READY:
  - clear = 1 → go to SWEEP, cnt = 0, ready = 0 next cycle.
  - If req is also 1 in that same cycle, the request is dropped.

Writes (READY, req = 1, we = 1):
- Lane i of word[address] is updated iff be[i] = 1; other lanes are unchanged.
- be = all-zero is a legal no-op.
- No q_valid; q holds its previous value.

Reads (READY, req = 1, we = 0):
- Address is registered; be is ignored.
- OUT_REG = 0: q = word[address] and q_valid = 1 in cycle N+1.
- OUT_REG = 1: both appear in cycle N+2.
- Back-to-back reads are fully pipelined, one result per cycle, in order.
- q holds the last read value until the next read completes.

Ordering and boundary rules:
- A write in cycle N followed by a read of the same address in cycle N+1 returns the written data, including partial-lane merge.
- Reads in flight when clear is accepted still complete with pre-sweep data.
- Reset mid-sweep aborts the sweep. With CLEAR_ON_RESET = 1 the sweep restarts from address 0 after reset release.
- address is used modulo depth; there are no out-of-range accesses.
- q_valid never asserts without a preceding accepted read.

Test Plan:
1. Reset with CLEAR_ON_RESET=1, ADDR_WIDTH=4 → ready = 0 for exactly 16 cycles after release. Reads of all 16 words then return 0x00000000.
2. Write 0xDEADBEEF be=1111 to addr 3, then write 0x000000AA be=0001 to addr 3, then read addr 3 → q = 0xDEADBEAA with q_valid one cycle after the read (OUT_REG=0), two cycles after (OUT_REG=1).
3. Back-to-back reads of addr 1,2,3 holding 0x11,0x22,0x33 → q_valid high three consecutive cycles with q = 0x11, 0x22, 0x33 in order, at both OUT_REG settings.
4. clear pulse while ready=1 with addr 5 = 0x12345678 → ready falls next cycle. Requests during the sweep produce no q_valid and no writes. After 16 cycles, a read of addr 5 returns 0.
5. Assert reset at sweep cnt = 7, release → sweep restarts at 0 and ready rises after a full 16 cycles. q = 0 and q_valid = 0 during reset.
6. CLEAR_ON_RESET=0 → ready = 1 immediately after reset release. Write with be=0000 to addr 2 after a prior write of 0xCAFEF00D → a read of addr 2 returns 0xCAFEF00D.

Source files
------------

// File: rtl/data_ram_be_if.sv
// rtl/data_ram_be_if.sv - load/store port bundle for data_ram_be
interface data_ram_be_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  logic                    req;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   data;
  logic [ADDR_WIDTH-1:0]   address;
  logic                    clear;
  logic [DATA_WIDTH-1:0]   q;
  logic                    q_valid;
  logic                    ready;

  modport master (
    output req, we, be, data, address, clear,
    input  q, q_valid, ready
  );

  modport slave (
    input  req, we, be, data, address, clear,
    output q, q_valid, ready
  );
endinterface

// File: rtl/data_ram_be.sv
// rtl/data_ram_be.sv - byte-enable data RAM with read handshake and zero-fill sweep
module data_ram_be #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 12,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic          clk,
  input  logic          reset,
  data_ram_be_if.slave  bus
);
  localparam int LANES = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {ST_SWEEP, ST_READY} state_t;

  state_t                state;
  state_t                state_nx;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  sweep_we;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if (CLEAR_ON_RESET != 0) state <= ST_SWEEP;
      else                     state <= ST_READY;
    end else begin
      state <= state_nx;
    end
  end

  // clear wins over a same-cycle request; nothing touches the array while reset is held
  always_comb begin
    state_nx = state;
    sweep_we = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    case (state)
      ST_SWEEP: begin
        sweep_we = 1'b1;
        if (cnt == '1) state_nx = ST_READY;
      end
      ST_READY: begin
        if (bus.clear) begin
          state_nx = ST_SWEEP;
        end else if (bus.req) begin
          wr_en = bus.we;
          rd_en = !bus.we;
        end
      end
      default: state_nx = ST_READY;
    endcase
    if (reset) begin
      sweep_we = 1'b0;
      wr_en    = 1'b0;
      rd_en    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (sweep_we) begin
      cnt <= cnt + 1'b1;
    end else if (state == ST_READY && bus.clear) begin
      cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[cnt] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.be[i]) mem[bus.address][8*i +: 8] <= bus.data[8*i +: 8];
      end
    end
  end

  // read-first capture: a write on the previous edge is already visible here
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= mem[bus.address];
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] q_r;
      logic                  q_valid_r;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          q_r       <= '0;
          q_valid_r <= 1'b0;
        end else begin
          q_valid_r <= rd_valid;
          if (rd_valid) q_r <= rd_data;
        end
      end
      assign bus.q       = q_r;
      assign bus.q_valid = q_valid_r;
    end else begin : g_no_out_reg
      assign bus.q       = rd_data;
      assign bus.q_valid = rd_valid;
    end
  endgenerate

  assign bus.ready = (state == ST_READY);
endmodule

// File: tb/tb_data_ram_be.sv
// tb/tb_data_ram_be.sv - self-checking bench for data_ram_be (two configurations side by side)
module tb_data_ram_be;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req, we, clear;
  logic [3:0]    be;
  logic [31:0]   data;
  logic [AW-1:0] address;

  always #5 clk = ~clk;

  data_ram_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_a ();
  data_ram_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_b ();

  assign bus_a.req = req;   assign bus_b.req = req;
  assign bus_a.we = we;     assign bus_b.we = we;
  assign bus_a.be = be;     assign bus_b.be = be;
  assign bus_a.data = data; assign bus_b.data = data;
  assign bus_a.address = address; assign bus_b.address = address;
  assign bus_a.clear = clear;     assign bus_b.clear = clear;

  data_ram_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(0), .CLEAR_ON_RESET(1))
    dut_a (.clk(clk), .reset(rst), .bus(bus_a));
  data_ram_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(1), .CLEAR_ON_RESET(0))
    dut_b (.clk(clk), .reset(rst), .bus(bus_b));

  // reference model: index 0 = dut_a, 1 = dut_b
  int          lat [2] = '{1, 2};
  bit          cor [2] = '{1'b1, 1'b0};
  logic [31:0] m_mem   [2][DEPTH];
  logic [3:0]  m_known [2][DEPTH];
  int          sweep_left [2];
  logic [31:0] exp_q  [2];
  logic [3:0]  exp_qk [2];
  logic        exp_qv [2];

  typedef struct {
    int          k;
    int          due;
    logic [31:0] d;
    logic [3:0]  km;
  } rd_t;
  rd_t pend[$];
  int  cyc = 0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{m[i]}};
    return r;
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      exp_qv[k] = 1'b0;
      if (rst) begin
        sweep_left[k] = cor[k] ? DEPTH : 0;
        exp_q[k]  = '0;
        exp_qk[k] = 4'hF;
        for (int i = pend.size() - 1; i >= 0; i--)
          if (pend[i].k == k) pend.delete(i);
      end else begin
        if (sweep_left[k] > 0) begin
          m_mem[k][DEPTH - sweep_left[k]]   = '0;
          m_known[k][DEPTH - sweep_left[k]] = 4'hF;
          sweep_left[k]--;
        end else if (clear) begin
          sweep_left[k] = DEPTH;
        end else if (req && we) begin
          for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
              m_mem[k][address][8*i +: 8] = data[8*i +: 8];
              m_known[k][address][i] = 1'b1;
            end
          end
        end else if (req) begin
          pend.push_back('{k, cyc + lat[k] - 1, m_mem[k][address], m_known[k][address]});
        end
        for (int i = pend.size() - 1; i >= 0; i--) begin
          if (pend[i].k == k && pend[i].due == cyc) begin
            exp_qv[k] = 1'b1;
            exp_q[k]  = pend[i].d;
            exp_qk[k] = pend[i].km;
            pend.delete(i);
          end
        end
      end
    end
    cyc++;
  endtask

  task automatic check_outputs();
    logic [31:0] lm;
    lm = lane_mask(exp_qk[0]);
    chk("ready_a", {31'b0, bus_a.ready}, {31'b0, sweep_left[0] == 0});
    chk("q_valid_a", {31'b0, bus_a.q_valid}, {31'b0, exp_qv[0]});
    if (exp_qk[0] != 4'h0) chk("q_a", bus_a.q & lm, exp_q[0] & lm);
    lm = lane_mask(exp_qk[1]);
    chk("ready_b", {31'b0, bus_b.ready}, {31'b0, sweep_left[1] == 0});
    chk("q_valid_b", {31'b0, bus_b.q_valid}, {31'b0, exp_qv[1]});
    if (exp_qk[1] != 4'h0) chk("q_b", bus_b.q & lm, exp_q[1] & lm);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    req = 1'b0; we = 1'b0; clear = 1'b0;
  endtask

  typedef struct {
    logic        w;
    logic [3:0]  b;
    logic [31:0] d;
    logic [3:0]  a;
    logic [31:0] exp;
  } vec_t;

  initial begin
    vec_t        tbl [20];
    int          n;
    int          first_a, first_b, cnt_a, cnt_b;
    logic [31:0] seq_a [3];
    logic [31:0] seq_b [3];
    logic [3:0]  b2b_addr [3];
    logic [31:0] b2b_exp [3];

    tbl[0]  = '{1'b1, 4'hF, 32'hDEADBEEF, 4'd3, 32'h0};
    tbl[1]  = '{1'b1, 4'h1, 32'h000000AA, 4'd3, 32'h0};
    tbl[2]  = '{1'b0, 4'h0, 32'h0,        4'd3, 32'hDEADBEAA};
    tbl[3]  = '{1'b1, 4'hF, 32'h00000011, 4'd1, 32'h0};
    tbl[4]  = '{1'b1, 4'hF, 32'h00000022, 4'd2, 32'h0};
    tbl[5]  = '{1'b1, 4'hF, 32'h00000033, 4'd3, 32'h0};
    tbl[6]  = '{1'b0, 4'hF, 32'h0,        4'd1, 32'h00000011};
    tbl[7]  = '{1'b0, 4'h0, 32'h0,        4'd2, 32'h00000022};
    tbl[8]  = '{1'b0, 4'h5, 32'h0,        4'd3, 32'h00000033};
    tbl[9]  = '{1'b1, 4'hF, 32'hCAFEF00D, 4'd2, 32'h0};
    tbl[10] = '{1'b1, 4'h0, 32'hFFFFFFFF, 4'd2, 32'h0};
    tbl[11] = '{1'b0, 4'h0, 32'h0,        4'd2, 32'hCAFEF00D};
    tbl[12] = '{1'b1, 4'hF, 32'h12345678, 4'd5, 32'h0};
    tbl[13] = '{1'b0, 4'h0, 32'h0,        4'd5, 32'h12345678};
    tbl[14] = '{1'b1, 4'hF, 32'hAABBCCDD, 4'd6, 32'h0};
    tbl[15] = '{1'b1, 4'h4, 32'h00110000, 4'd6, 32'h0};
    tbl[16] = '{1'b0, 4'h0, 32'h0,        4'd6, 32'hAA11CCDD};
    tbl[17] = '{1'b1, 4'hF, 32'h11223344, 4'd7, 32'h0};
    tbl[18] = '{1'b1, 4'hA, 32'h55667788, 4'd7, 32'h0};
    tbl[19] = '{1'b0, 4'h0, 32'h0,        4'd7, 32'h55227744};

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[k][i]   = '0;
        m_known[k][i] = 4'h0;
      end
      exp_q[k] = '0; exp_qk[k] = 4'hF; exp_qv[k] = 1'b0; sweep_left[k] = 0;
    end

    rst = 1'b1; be = 4'h0; data = '0; address = '0;
    idle();
    repeat (3) cycle();

    // zero-fill after reset release, then every word reads back as zero
    rst = 1'b0;
    chk("ready_b_after_reset", {31'b0, bus_b.ready}, 32'd1);
    n = 0;
    while (!bus_a.ready && n < 40) begin cycle(); n++; end
    chk("sweep_len_reset", n, 16);
    for (int a = 0; a < DEPTH; a++) begin
      req = 1'b1; we = 1'b0; address = AW'(a);
      cycle();
    end
    idle(); cycle(); cycle();

    for (int i = 0; i < 20; i++) begin
      req = 1'b1; we = tbl[i].w; be = tbl[i].b; data = tbl[i].d; address = tbl[i].a;
      cycle();
      idle(); cycle(); cycle();
      if (!tbl[i].w) begin
        chk("tbl_q_a", bus_a.q, tbl[i].exp);
        chk("tbl_q_b", bus_b.q, tbl[i].exp);
      end
    end

    // partial write immediately followed by a read of the same word
    req = 1'b1; we = 1'b1; be = 4'hF; data = 32'h0F0F0F0F; address = 4'd9; cycle();
    be = 4'h3; data = 32'h0000ABCD; cycle();
    we = 1'b0; cycle();
    idle(); cycle(); cycle();
    chk("wr_rd_q_a", bus_a.q, 32'h0F0FABCD);
    chk("wr_rd_q_b", bus_b.q, 32'h0F0FABCD);

    b2b_addr = '{4'd1, 4'd5, 4'd6};
    b2b_exp  = '{32'h00000011, 32'h12345678, 32'hAA11CCDD};
    first_a = -1; first_b = -1; cnt_a = 0; cnt_b = 0;
    for (int c = 0; c < 6; c++) begin
      if (c < 3) begin req = 1'b1; we = 1'b0; address = b2b_addr[c]; end
      else idle();
      cycle();
      if (bus_a.q_valid) begin
        if (first_a < 0) first_a = c;
        if (cnt_a < 3) seq_a[cnt_a] = bus_a.q;
        cnt_a++;
      end
      if (bus_b.q_valid) begin
        if (first_b < 0) first_b = c;
        if (cnt_b < 3) seq_b[cnt_b] = bus_b.q;
        cnt_b++;
      end
    end
    chk("b2b_first_a", first_a, 0);
    chk("b2b_first_b", first_b, 1);
    chk("b2b_count_a", cnt_a, 3);
    chk("b2b_count_b", cnt_b, 3);
    for (int i = 0; i < 3; i++) begin
      chk("b2b_seq_a", (i < cnt_a) ? seq_a[i] : 32'hx, b2b_exp[i]);
      chk("b2b_seq_b", (i < cnt_b) ? seq_b[i] : 32'hx, b2b_exp[i]);
    end

    // clear with a read in flight and a dropped same-cycle write
    req = 1'b1; we = 1'b0; address = 4'd6; cycle();
    clear = 1'b1; we = 1'b1; be = 4'hF; data = 32'hFFFFFFFF; address = 4'd5; cycle();
    clear = 1'b0;
    chk("clear_ready_a", {31'b0, bus_a.ready}, 32'd0);
    chk("clear_ready_b", {31'b0, bus_b.ready}, 32'd0);
    chk("inflight_q_b", bus_b.q, 32'hAA11CCDD);
    n = 0;
    while (!bus_a.ready && n < 40) begin
      req = $urandom_range(0, 1); we = $urandom_range(0, 1); be = 4'($urandom);
      data = $urandom; address = 4'($urandom); clear = ($urandom_range(0, 3) == 0);
      cycle(); n++;
    end
    chk("sweep_len_clear", n, 16);
    req = 1'b1; we = 1'b0; address = 4'd5; clear = 1'b0; cycle();
    idle(); cycle(); cycle();
    chk("cleared_q_a", bus_a.q, 32'h0);
    chk("cleared_q_b", bus_b.q, 32'h0);

    // reset in the middle of a sweep
    clear = 1'b1; cycle(); clear = 1'b0;
    repeat (7) cycle();
    rst = 1'b1;
    #1;
    chk("rst_q_a", bus_a.q, 32'h0);
    chk("rst_qv_b", {31'b0, bus_b.q_valid}, 32'd0);
    cycle(); cycle();
    rst = 1'b0;
    chk("ready_b_rst_release", {31'b0, bus_b.ready}, 32'd1);
    n = 0;
    while (!bus_a.ready && n < 40) begin cycle(); n++; end
    chk("sweep_len_abort", n, 16);

    for (int c = 0; c < 400; c++) begin
      req = $urandom_range(0, 1); we = $urandom_range(0, 1); be = 4'($urandom);
      data = $urandom; address = 4'($urandom); clear = ($urandom_range(0, 49) == 0);
      cycle();
    end
    idle();
    repeat (3) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
